// File: rtl/wb_bram_burst_if.sv
// wb_bram_burst_if: Wishbone B4 slave bus bundle for wb_bram_burst
//   adr     byte address              dat_ms  write data (master->slave)
//   dat_sm  read data (slave->master) sel     byte enables
//   cyc/stb bus cycle / strobe        we      1 = write
//   cti/bte cycle type / burst type   ack/err/rty  terminations
interface wb_bram_burst_if #(
  parameter int ADR_WIDTH  = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADR_WIDTH-1:0]    adr;
  logic [DATA_WIDTH-1:0]   dat_ms;
  logic [DATA_WIDTH-1:0]   dat_sm;
  logic [DATA_WIDTH/8-1:0] sel;
  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic [2:0]              cti;
  logic [1:0]              bte;
  logic                    ack;
  logic                    err;
  logic                    rty;
  modport master (
    output adr, dat_ms, sel, cyc, stb, we, cti, bte,
    input  dat_sm, ack, err, rty
  );
  modport slave (
    input  adr, dat_ms, sel, cyc, stb, we, cti, bte,
    output dat_sm, ack, err, rty
  );
endinterface

// File: rtl/wb_bram_burst.sv
// wb_bram_burst: Wishbone B4 BlockRAM slave with byte selects and CTI/BTE bursts
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    wb_bram_burst_if.slave (adr, dat_ms, dat_sm, sel, cyc, stb, we,
//          cti, bte, ack, err, rty)
//   Optional macro WB_BRAM_BURST_ERR_EN: out-of-range addresses answer with
//   err instead of ack and never write memory; undefined, upper bits alias.
module wb_bram_burst #(
  parameter int MEM_ADR_WIDTH = 11,
  parameter int DATA_WIDTH    = 32,
  parameter int ADR_WIDTH     = 32
) (
  input logic           clk,
  input logic           rst_n,
  wb_bram_burst_if.slave bus
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int B  = $clog2(NB);
  localparam int AW = MEM_ADR_WIDTH;
  typedef logic [AW-1:0] word_t;
  logic [DATA_WIDTH-1:0] mem [2**AW];
  logic [DATA_WIDTH-1:0] rdata;
  word_t wa, tag, rd_ptr, mask, nxt;
  logic tag_valid, req, hit, bad, burst, wr, tag_kill, unused_adr;
  assign wa    = bus.adr[AW+B-1:B];
  assign req   = rst_n & bus.cyc & bus.stb;
  assign burst = bus.cti == 3'b010;
`ifdef WB_BRAM_BURST_ERR_EN
  assign bad = |bus.adr[ADR_WIDTH-1:AW+B];
`else
  assign bad = 1'b0;
`endif
  // byte-offset bits (and aliased upper bits) carry no information here
  assign unused_adr = ^bus.adr;
  // writes terminate at once; reads only when the prefetched tag matches
  assign hit      = req & (bus.we | (tag_valid & tag == wa));
  assign bus.ack  = hit & ~bad;
  assign bus.err  = hit & bad;
  assign bus.rty  = 1'b0;
  assign bus.dat_sm = rdata;
  assign wr = req & bus.we & ~bad;
  // wrapping bursts only advance the low bits of the word index
  always_comb begin
    mask = bus.bte == 2'b01 ? word_t'(3) :
           bus.bte == 2'b10 ? word_t'(7) :
           bus.bte == 2'b11 ? word_t'(15) : '1;
    nxt  = (wa & ~mask) | ((wa + 1'b1) & mask);
    rd_ptr = (bus.ack & ~bus.we & burst) ? nxt : wa;
    // a write makes the prefetched word stale; a final or errored read beat
    // must not be answered again from the same prefetch
    tag_kill = ~bus.cyc | (req & bus.we) | (hit & ~bus.we & (~burst | bad));
  end
  always_ff @(posedge clk)
    if (wr)
      for (int i = 0; i < NB; i++)
        if (bus.sel[i]) mem[wa][8*i +: 8] <= bus.dat_ms[8*i +: 8];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rdata     <= '0;
      tag       <= '0;
      tag_valid <= 1'b0;
    end else begin
      rdata     <= mem[rd_ptr];
      tag       <= rd_ptr;
      tag_valid <= ~tag_kill;
    end
endmodule

// File: tb/tb_wb_bram_burst.sv
// tb_wb_bram_burst: directed self-checking bench for wb_bram_burst
module tb_wb_bram_burst;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_mem [16];
  wb_bram_burst_if #(.ADR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  wb_bram_burst #(.MEM_ADR_WIDTH(11), .DATA_WIDTH(32), .ADR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic cyc, stb, we;
    logic [31:0] adr, dat;
    logic [3:0] sel;
    logic [2:0] cti;
    logic [1:0] bte;
    logic ack, err, chk;
    logic [31:0] rd;
  } vec_t;
  vec_t v[$];
  function automatic vec_t mk(input logic c, s, w, input logic [31:0] a, d,
                              input logic [3:0] sl, input logic [2:0] ct,
                              input logic [1:0] bt, input logic ak, er, ck,
                              input logic [31:0] rd);
    vec_t r;
    r.cyc = c; r.stb = s; r.we = w; r.adr = a; r.dat = d; r.sel = sl;
    r.cti = ct; r.bte = bt; r.ack = ak; r.err = er; r.chk = ck; r.rd = rd;
    return r;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic c, s, w, input logic [31:0] a, d,
                       input logic [3:0] sl, input logic [2:0] ct, input logic [1:0] bt);
    @(posedge clk);
    #1;
    bus.cyc = c; bus.stb = s; bus.we = w; bus.adr = a; bus.dat_ms = d;
    bus.sel = sl; bus.cti = ct; bus.bte = bt;
    #1;
  endtask
  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  function automatic int seq_word(input int w0, input int beat, input logic [1:0] bte);
    int m;
    m = bte == 2'b01 ? 3 : bte == 2'b10 ? 7 : bte == 2'b11 ? 15 : 32'h7ff;
    return (w0 & ~m) | ((w0 + beat) & m);
  endfunction
  // master model: advances the address on every ack, optionally drops stb
  // for stall_len cycles (holding the previous beat address) before beat stall_at
  task automatic burst(input string name, input int w0, input int n, input logic [1:0] bte,
                       input int stall_at, input int stall_len, input int exp_span);
    int beat = 0, cnt = 0, first = -1, last = -1, stall = 0, w;
    while (beat < n && cnt < 100) begin
      if (beat == stall_at && stall < stall_len) begin
        drive(1, 0, 0, seq_word(w0, beat - 1, bte) * 4, 0, 0, 3'b010, bte);
        stall++;
        check({name, "_stall_ack"}, {31'b0, bus.ack}, 0);
      end else begin
        w = seq_word(w0, beat, bte);
        drive(1, 1, 0, w * 4, 0, 0, beat == n - 1 ? 3'b111 : 3'b010, bte);
        if (bus.ack) begin
          check($sformatf("%s_beat%0d", name, beat), bus.dat_sm, exp_mem[w]);
          if (first < 0) first = cnt;
          last = cnt;
          beat++;
        end
      end
      cnt++;
    end
    check({name, "_beats"}, beat, n);
    check({name, "_span"}, last - first, exp_span);
    drive(1, 1, 0, seq_word(w0, n - 1, bte) * 4, 0, 0, 3'b111, bte);
    check({name, "_hold_ack"}, {31'b0, bus.ack}, 0);
    idle();
    check({name, "_idle_ack"}, {31'b0, bus.ack}, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] w8;
    bus.cyc = 0; bus.stb = 0; bus.we = 0; bus.adr = 0; bus.dat_ms = 0;
    bus.sel = 0; bus.cti = 0; bus.bte = 0;
    #1;
    check("reset_ack", {31'b0, bus.ack}, 0);
    check("reset_dat", bus.dat_sm, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_mem[i] = 32'hC0DE_0000 + i;
      drive(1, 1, 1, i * 4, exp_mem[i], 4'hF, 3'b000, 2'b00);
      check($sformatf("fill_ack%0d", i), {31'b0, bus.ack}, 1);
    end
    idle();
`ifdef WB_BRAM_BURST_ERR_EN
    w8 = 32'hC0DE_0008;
`else
    w8 = 32'h5555_5555;
`endif
    v.push_back(mk(1, 1, 1, 32'h10, 32'hDEAD_BEEF, 4'hF, 3'b000, 2'b00, 1, 0, 0, 0));
    v.push_back(mk(1, 1, 1, 32'h10, 32'h0000_00AA, 4'h1, 3'b000, 2'b00, 1, 0, 0, 0));
    v.push_back(mk(1, 1, 0, 32'h10, 0, 0, 3'b000, 2'b00, 0, 0, 0, 0));
    v.push_back(mk(1, 1, 0, 32'h10, 0, 0, 3'b000, 2'b00, 1, 0, 1, 32'hDEAD_BEAA));
    v.push_back(mk(1, 1, 0, 32'h10, 0, 0, 3'b000, 2'b00, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 0, 0, 0, 0));
    v.push_back(mk(1, 1, 0, 32'h18, 0, 0, 3'b010, 2'b01, 0, 0, 0, 0));
    v.push_back(mk(1, 1, 0, 32'h18, 0, 0, 3'b010, 2'b01, 1, 0, 1, 32'hC0DE_0006));
    v.push_back(mk(1, 1, 0, 32'h1C, 0, 0, 3'b010, 2'b01, 1, 0, 1, 32'hC0DE_0007));
    v.push_back(mk(1, 1, 0, 32'h10, 0, 0, 3'b010, 2'b01, 1, 0, 1, 32'hDEAD_BEAA));
    v.push_back(mk(1, 1, 0, 32'h14, 0, 0, 3'b111, 2'b01, 1, 0, 1, 32'hC0DE_0005));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 0, 0, 0, 0));
`ifdef WB_BRAM_BURST_ERR_EN
    v.push_back(mk(1, 1, 1, 32'h2020, 32'h5555_5555, 4'hF, 3'b000, 2'b00, 0, 1, 0, 0));
`else
    v.push_back(mk(1, 1, 1, 32'h2020, 32'h5555_5555, 4'hF, 3'b000, 2'b00, 1, 0, 0, 0));
`endif
    v.push_back(mk(1, 1, 0, 32'h20, 0, 0, 3'b000, 2'b00, 0, 0, 0, 0));
    v.push_back(mk(1, 1, 0, 32'h20, 0, 0, 3'b000, 2'b00, 1, 0, 1, w8));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 0, 0, 0, 0));
    v.push_back(mk(1, 1, 1, 32'h24, 32'hFFFF_FFFF, 4'h0, 3'b000, 2'b00, 1, 0, 0, 0));
    v.push_back(mk(1, 1, 0, 32'h24, 0, 0, 3'b000, 2'b00, 0, 0, 0, 0));
    v.push_back(mk(1, 1, 0, 32'h24, 0, 0, 3'b000, 2'b00, 1, 0, 1, 32'hC0DE_0009));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 0, 0, 0, 0));
    foreach (v[i]) begin
      drive(v[i].cyc, v[i].stb, v[i].we, v[i].adr, v[i].dat, v[i].sel, v[i].cti, v[i].bte);
      check($sformatf("vec%0d_ack", i), {31'b0, bus.ack}, {31'b0, v[i].ack});
      check($sformatf("vec%0d_err", i), {31'b0, bus.err}, {31'b0, v[i].err});
      if (v[i].chk) check($sformatf("vec%0d_dat", i), bus.dat_sm, v[i].rd);
    end
    exp_mem[4] = 32'hDEAD_BEAA;
    exp_mem[8] = w8;
    burst("linear8", 0, 8, 2'b00, -1, 0, 7);
    burst("wrap4", 6, 4, 2'b01, -1, 0, 3);
    burst("stall6", 2, 6, 2'b00, 3, 2, 8);
    drive(1, 1, 0, 0, 0, 0, 3'b010, 2'b00);
    drive(1, 1, 0, 0, 0, 0, 3'b010, 2'b00);
    check("pre_reset_ack", {31'b0, bus.ack}, 1);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_ack", {31'b0, bus.ack}, 0);
    check("midreset_err", {31'b0, bus.err}, 0);
    check("midreset_dat", bus.dat_sm, 0);
    idle();
    idle();
    #1 rst_n = 1'b1;
    idle();
    drive(1, 1, 0, 32'h14, 0, 0, 3'b000, 2'b00);
    check("post_reset_n_ack", {31'b0, bus.ack}, 0);
    drive(1, 1, 0, 32'h14, 0, 0, 3'b000, 2'b00);
    check("post_reset_n1_ack", {31'b0, bus.ack}, 1);
    check("post_reset_dat", bus.dat_sm, 32'hC0DE_0005);
    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
